// File: rtl/mem_slave_ctrl_if.sv
// SEL/WR_RDbar/ADDR/WDATA request and READY/RDATA response bus of mem_slave_ctrl.
// PERR_INJ/PERR exist only when MEM_PARITY_EN is defined.
interface mem_slave_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              SEL;
  logic              WR_RDbar;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic              READY;
  logic [DATA_W-1:0] RDATA;
`ifdef MEM_PARITY_EN
  logic              PERR_INJ;
  logic              PERR;

  modport master (output SEL, WR_RDbar, ADDR, WDATA, PERR_INJ, input READY, RDATA, PERR);
  modport slave  (input SEL, WR_RDbar, ADDR, WDATA, PERR_INJ, output READY, RDATA, PERR);
`else
  modport master (output SEL, WR_RDbar, ADDR, WDATA, input READY, RDATA);
  modport slave  (input SEL, WR_RDbar, ADDR, WDATA, output READY, RDATA);
`endif
endinterface

// File: rtl/mem_slave_ctrl.sv
// Memory slave: SEL held by master, READY strobes one cycle WAIT_STATES edges after capture; SEL drop in WAIT aborts.
// MEM_PARITY_EN adds a stored even-parity bit, PERR_INJ corruption input and PERR read-check output.
module mem_slave_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input logic              clk,
  input logic              RST_n,
  mem_slave_ctrl_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                w_capture, w_access;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_from_bus;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [MEM_W-1:0]    w_wr_word;
  logic [MEM_W-1:0]    w_rd_word;
  logic [MEM_W-1:0]    mem [DEPTH];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.SEL) begin
          w_capture = 1'b1;
          w_cnt_nxt = WS;
          if (WS == 4'd0) begin
            w_state_nxt = S_RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.SEL) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Zero-wait accesses happen on the capture edge, so they take the live bus.
  assign w_from_bus  = (r_state == S_IDLE);
  assign w_acc_wr    = w_from_bus ? bus.WR_RDbar : r_wr;
  assign w_acc_addr  = w_from_bus ? bus.ADDR     : r_addr;
  assign w_acc_wdata = w_from_bus ? bus.WDATA    : r_wdata;
  assign w_rd_word   = mem[w_acc_addr];

`ifdef MEM_PARITY_EN
  logic r_inj;
  logic r_perr;
  logic w_acc_inj;

  assign w_acc_inj = w_from_bus ? bus.PERR_INJ : r_inj;
  assign w_wr_word = {(^w_acc_wdata) ^ w_acc_inj, w_acc_wdata};
  assign bus.PERR  = r_perr;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_inj  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_capture) r_inj <= bus.PERR_INJ;
      // Odd parity over {stored bit, data} means the stored bit disagrees.
      r_perr <= w_access && !w_acc_wr && (^w_rd_word);
    end
  end
`else
  assign w_wr_word = w_acc_wdata;
`endif

  // Array has no reset; the RST_n term keeps a write from landing while reset is held.
  always_ff @(posedge clk or negedge RST_n) begin
    if (RST_n && w_access && w_acc_wr) mem[w_acc_addr] <= w_wr_word;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_access;
      if (w_capture) begin
        r_wr    <= bus.WR_RDbar;
        r_addr  <= bus.ADDR;
        r_wdata <= bus.WDATA;
      end
      if (w_access && !w_acc_wr) r_rdata <= w_rd_word[DATA_W-1:0];
    end
  end

  assign bus.READY = r_ready;
  assign bus.RDATA = r_rdata;

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Scoreboard bench: two DUTs (WAIT_STATES 0 and 3) driven in parallel, expectations queued at issue and popped on READY.
module tb_mem_slave_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WS_A = 0;
  localparam int WS_B = 3;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_slave_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 (), bus1 ();

  mem_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_A)) u_dut0 (.clk(clk), .RST_n(rst_a), .bus(bus0));
  mem_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_B)) u_dut1 (.clk(clk), .RST_n(rst_b), .bus(bus1));

  typedef struct {
    int          cyc;
    logic [15:0] rd;
    bit          perr;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mdl_mem  [2][256];
  bit          mdl_vld  [2][256];
  bit          mdl_par  [2][256];
  logic [15:0] mdl_last [2];

  function automatic int ws(input int d);
    return (d == 0) ? WS_A : WS_B;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.READY : bus1.READY;
  endfunction

  function automatic logic [15:0] rdat(input int d);
    return (d == 0) ? bus0.RDATA : bus1.RDATA;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input bit sel, input bit wr, input logic [7:0] a, input logic [15:0] wd);
    if (d == 0) begin
      bus0.SEL = sel; bus0.WR_RDbar = wr; bus0.ADDR = a; bus0.WDATA = wd;
`ifdef MEM_PARITY_EN
      bus0.PERR_INJ = 1'b0;
`endif
    end else begin
      bus1.SEL = sel; bus1.WR_RDbar = wr; bus1.ADDR = a; bus1.WDATA = wd;
`ifdef MEM_PARITY_EN
      bus1.PERR_INJ = 1'b0;
`endif
    end
  endtask

  // Reference model: a transaction captured at edge e0 completes with READY visible after e0+WS.
  task automatic expect_txn(input int d, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                            input bit inj, input int e0);
    exp_t e;
    e.cyc  = e0 + ws(d);
    e.perr = 1'b0;
    if (wr) begin
      mdl_mem[d][a] = wd;
      mdl_vld[d][a] = 1'b1;
      mdl_par[d][a] = inj;
      e.rd = mdl_last[d];
    end else begin
      e.rd   = mdl_mem[d][a];
      e.perr = mdl_par[d][a];
      mdl_last[d] = e.rd;
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    @(negedge clk);
    while (!rdy(d) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_seen dut%0d", d), 32'(rdy(d)), 32'd1);
  endtask

  // Called at a negedge; b2b means the DUT is showing READY now and spends one edge in RESP.
  task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                     input bit inj, input bit b2b);
    expect_txn(d, wr, a, wd, inj, b2b ? cyc + 2 : cyc + 1);
    drive(d, 1'b1, wr, a, wd);
`ifdef MEM_PARITY_EN
    if (d == 0) bus0.PERR_INJ = inj;
    else        bus1.PERR_INJ = inj;
`endif
    wait_ready(d);
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_ready dut%0d: READY=1 at cycle %0d, expected 0", d, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("ready_cycle dut%0d", d), 32'(cyc), 32'(e.cyc));
    chk($sformatf("rdata dut%0d", d), 32'(rdat(d)), 32'(e.rd));
`ifdef MEM_PARITY_EN
    chk($sformatf("perr dut%0d", d), 32'((d == 0) ? bus0.PERR : bus1.PERR), 32'(e.perr));
`endif
  endtask

  always @(negedge clk) begin
    if (bus0.READY === 1'b1) mon(0);
    if (bus1.READY === 1'b1) mon(1);
  end

  task automatic run(input int d);
    bit          b2b;
    logic [7:0]  a;
    bit          wr;
    txn(d, 1'b1, 8'h10, 16'hABCD, 1'b0, 1'b0); idle(d);
    txn(d, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0); idle(d);
    txn(d, 1'b1, 8'h00, 16'h1357, 1'b0, 1'b0);
    txn(d, 1'b1, 8'hFF, 16'h2468, 1'b0, 1'b1);
    txn(d, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    txn(d, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b1); idle(d);
    if (d == 1) begin
      // Abort a read mid-WAIT: no READY, RDATA and the array untouched.
      txn(d, 1'b1, 8'h20, 16'hC0DE, 1'b0, 1'b0); idle(d);
      txn(d, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0); idle(d);
      txn(d, 1'b1, 8'h21, 16'h0F0F, 1'b0, 1'b0); idle(d);
      drive(d, 1'b1, 1'b0, 8'h21, 16'h0000);
      @(negedge clk);
      drive(d, 1'b0, 1'b0, 8'h00, 16'h0000);
      repeat (8) @(negedge clk);
      chk("abort_rdata_held", 32'(bus1.RDATA), 32'(mdl_last[1]));
      txn(d, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0); idle(d);
      // Reset during WAIT of a write: outputs clear at once, old data survives.
      txn(d, 1'b1, 8'h30, 16'h5555, 1'b0, 1'b0); idle(d);
      drive(d, 1'b1, 1'b1, 8'h30, 16'h1234);
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("midrst_ready", 32'(bus1.READY), 32'd0);
      chk("midrst_rdata", 32'(bus1.RDATA), 32'd0);
      mdl_last[1] = 16'h0000;
      drive(d, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      txn(d, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0); idle(d);
      // Bus changes during WAIT must not affect the captured request.
      txn(d, 1'b1, 8'h41, 16'h7777, 1'b0, 1'b0); idle(d);
      expect_txn(d, 1'b1, 8'h40, 16'hAAAA, 1'b0, cyc + 1);
      drive(d, 1'b1, 1'b1, 8'h40, 16'hAAAA);
      @(negedge clk);
      drive(d, 1'b1, 1'b1, 8'h41, 16'hBBBB);
      wait_ready(d); idle(d);
      txn(d, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0);
      txn(d, 1'b0, 8'h41, 16'h0000, 1'b0, 1'b1); idle(d);
    end
    txn(d, 1'b1, 8'h50, 16'h0001, 1'b1, 1'b0); idle(d);
    txn(d, 1'b0, 8'h50, 16'h0000, 1'b0, 1'b0); idle(d);
    txn(d, 1'b1, 8'h50, 16'h0001, 1'b0, 1'b0); idle(d);
    txn(d, 1'b0, 8'h50, 16'h0000, 1'b0, 1'b0); idle(d);
    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      a  = 8'($urandom_range(0, 255));
      wr = ($urandom_range(0, 1) == 1) || !mdl_vld[d][a];
      txn(d, wr, a, 16'($urandom), ($urandom_range(0, 3) == 0), b2b);
      if ($urandom_range(0, 2) == 0) begin
        b2b = 1'b1;
      end else begin
        idle(d);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        b2b = 1'b0;
      end
    end
    idle(d);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      mdl_last[d] = 16'h0000;
      for (int j = 0; j < 256; j++) begin
        mdl_vld[d][j] = 1'b0;
        mdl_par[d][j] = 1'b0;
        mdl_mem[d][j] = 16'h0000;
      end
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b1, 1'b1, 8'h05, 16'hFFFF);
    drive(1, 1'b1, 1'b1, 8'h05, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("reset_ready dut0", 32'(bus0.READY), 32'd0);
    chk("reset_rdata dut0", 32'(bus0.RDATA), 32'd0);
    chk("reset_ready dut1", 32'(bus1.READY), 32'd0);
    chk("reset_rdata dut1", 32'(bus1.RDATA), 32'd0);
`ifdef MEM_PARITY_EN
    chk("reset_perr dut0", 32'(bus0.PERR), 32'd0);
    chk("reset_perr dut1", 32'(bus1.PERR), 32'd0);
`endif
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    fork
      run(0);
      run(1);
    join
    chk("drained dut0", 32'(q0.size()), 32'd0);
    chk("drained dut1", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
